// File: rtl/instr_block_pkg.sv
// instr_block_pkg: shared defaults, block entry type and slot extraction helper
// Provides default widths, the blk_entry_t FIFO entry, slot_word() and a NOP word.
package instr_block_pkg;
  localparam int INSTR_W_DEF = 32;
  localparam int INSTR_PER_BLOCK_DEF = 4;
  localparam int ID_W_DEF = 7;
  localparam logic [31:0] NOP = 32'h00000013;
  typedef struct packed {
    logic [ID_W_DEF-1:0] id;
    logic [INSTR_PER_BLOCK_DEF*INSTR_W_DEF-1:0] payload;
  } blk_entry_t;
  // Slot 0 occupies the most significant word of the payload.
  function automatic logic [INSTR_W_DEF-1:0] slot_word(
    input logic [INSTR_PER_BLOCK_DEF*INSTR_W_DEF-1:0] payload,
    input logic [$clog2(INSTR_PER_BLOCK_DEF)-1:0] slot
  );
    return payload[(INSTR_PER_BLOCK_DEF-1-int'(slot))*INSTR_W_DEF +: INSTR_W_DEF];
  endfunction
endpackage

// File: rtl/instr_block_fifo.sv
// instr_block_fifo: synchronous FIFO of block entries with flush
// Ports: clk, reset_n (async, active-high), flush_i empties, push_i/wdata_i write tail,
// pop_i/rdata_o read head, full_o/empty_o/count_o status.
module instr_block_fifo
  import instr_block_pkg::*;
#(
  parameter type T = blk_entry_t,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  T                           wdata_i,
  output T                           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);
  T mem_q [DEPTH];
  // Extra MSB on each pointer distinguishes full from empty when the indices match.
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  always_comb begin
    wr_d = flush_i ? '0 : wr_q + {{AW{1'b0}}, push_i};
    rd_d = flush_i ? '0 : rd_q + {{AW{1'b0}}, pop_i};
  end
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end
  assign count_o = wr_q - rd_q;
  assign empty_o = wr_q == rd_q;
  assign full_o  = count_o == (AW+1)'(DEPTH);
  assign rdata_o = mem_q[rd_q[AW-1:0]];
endmodule

// File: rtl/instr_block_issue_queue.sv
// instr_block_issue_queue: queues instruction blocks and issues one instruction per cycle
// Ports: blk_* block input handshake, ins_* instruction output handshake with id/slot/last,
// flush_i discards everything, occupancy_o blocks held, drop_cnt_o saturating rejected offers.
module instr_block_issue_queue
  import instr_block_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int INSTR_PER_BLOCK = INSTR_PER_BLOCK_DEF,
  parameter int ID_W = ID_W_DEF,
  parameter int DEPTH = 4,
  parameter int DROP_W = 16,
  localparam int SW = INSTR_PER_BLOCK > 1 ? $clog2(INSTR_PER_BLOCK) : 1
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               blk_valid_i,
  output logic                               blk_ready_o,
  input  logic [INSTR_PER_BLOCK*INSTR_W-1:0] blk_data_i,
  input  logic [ID_W-1:0]                    blk_id_i,
  input  logic                               flush_i,
  output logic                               ins_valid_o,
  input  logic                               ins_ready_i,
  output logic [INSTR_W-1:0]                 ins_data_o,
  output logic [ID_W-1:0]                    ins_id_o,
  output logic [SW-1:0]                      ins_slot_o,
  output logic                               ins_last_o,
  output logic [$clog2(DEPTH+1)-1:0]         occupancy_o,
  output logic [DROP_W-1:0]                  drop_cnt_o
);
  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [INSTR_PER_BLOCK*INSTR_W-1:0] payload;
  } entry_t;
  entry_t wr_entry, head;
  logic full, empty, push, pop, xfer, last_slot;
  logic [SW-1:0] slot_q, slot_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic [INSTR_W-1:0] word;
  assign wr_entry = '{id: blk_id_i, payload: blk_data_i};
  instr_block_fifo #(.T(entry_t), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush_i (flush_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wr_entry),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (occupancy_o)
  );
  always_comb begin
    last_slot = slot_q == SW'(INSTR_PER_BLOCK-1);
    xfer = !empty && ins_ready_i;
    pop = xfer && last_slot;
    // Flush wins over a same-cycle offer, which is then neither queued nor counted as a drop.
    push = blk_valid_i && !full && !flush_i;
    slot_d = (flush_i || pop) ? '0 : xfer ? slot_q + SW'(1) : slot_q;
    drop_d = (blk_valid_i && full && !flush_i && drop_q != '1) ? drop_q + DROP_W'(1) : drop_q;
    word = head.payload[(INSTR_PER_BLOCK-1-int'(slot_q))*INSTR_W +: INSTR_W];
    blk_ready_o = !full;
    ins_valid_o = !empty;
    ins_data_o = ins_valid_o ? word : '0;
    ins_id_o = ins_valid_o ? head.id : '0;
    ins_slot_o = ins_valid_o ? slot_q : '0;
    ins_last_o = ins_valid_o && last_slot;
    drop_cnt_o = drop_q;
  end
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      slot_q <= '0;
      drop_q <= '0;
    end else begin
      slot_q <= slot_d;
      drop_q <= drop_d;
    end
  end
endmodule

// File: tb/tb_instr_block_issue_queue.sv
// tb_instr_block_issue_queue: randomized scoreboard bench for the block issue queue
module tb_instr_block_issue_queue;
  localparam int IW = 32;
  localparam int IPB = 4;
  localparam int IDW = 7;
  localparam int DEPTH = 4;
  localparam int DW = 16;
  localparam int SW = $clog2(IPB);
  localparam int CW = $clog2(DEPTH+1);

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic blk_valid_i = 1'b0;
  logic blk_ready_o;
  logic [IPB*IW-1:0] blk_data_i = '0;
  logic [IDW-1:0] blk_id_i = '0;
  logic flush_i = 1'b0;
  logic ins_valid_o;
  logic ins_ready_i = 1'b0;
  logic [IW-1:0] ins_data_o;
  logic [IDW-1:0] ins_id_o;
  logic [SW-1:0] ins_slot_o;
  logic ins_last_o;
  logic [CW-1:0] occupancy_o;
  logic [DW-1:0] drop_cnt_o;

  instr_block_issue_queue #(
    .INSTR_W(IW), .INSTR_PER_BLOCK(IPB), .ID_W(IDW), .DEPTH(DEPTH), .DROP_W(DW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .blk_valid_i(blk_valid_i), .blk_ready_o(blk_ready_o),
    .blk_data_i(blk_data_i), .blk_id_i(blk_id_i), .flush_i(flush_i),
    .ins_valid_o(ins_valid_o), .ins_ready_i(ins_ready_i), .ins_data_o(ins_data_o),
    .ins_id_o(ins_id_o), .ins_slot_o(ins_slot_o), .ins_last_o(ins_last_o),
    .occupancy_o(occupancy_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0] data;
    logic [IDW-1:0] id;
    int slot;
    bit last;
  } exp_t;

  exp_t exp_q[$];
  logic [IW-1:0] cur_w [IPB];
  int mblk = 0;
  logic [DW-1:0] mdrop = '0;
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_reset();
    chk("rst_blk_ready", 64'(blk_ready_o), 64'd1);
    chk("rst_ins_valid", 64'(ins_valid_o), 64'd0);
    chk("rst_ins_data", 64'(ins_data_o), 64'd0);
    chk("rst_ins_id", 64'(ins_id_o), 64'd0);
    chk("rst_ins_slot", 64'(ins_slot_o), 64'd0);
    chk("rst_ins_last", 64'(ins_last_o), 64'd0);
    chk("rst_occupancy", 64'(occupancy_o), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt_o), 64'd0);
  endtask

  // Monitor and reference model: checks at the falling edge, advances the model at the rising edge.
  initial begin
    bit pl;
    bit rdy;
    exp_t e;
    pl = 1'b0;
    forever begin
      @(negedge clk or posedge reset_n);
      pl = 1'b0;
      if (reset_n) begin
        exp_q.delete();
        mblk = 0;
        mdrop = '0;
        #1 check_reset();
      end else begin
        chk("blk_ready", 64'(blk_ready_o), 64'(mblk < DEPTH));
        chk("occupancy", 64'(occupancy_o), 64'(mblk));
        chk("drop_cnt", 64'(drop_cnt_o), 64'(mdrop));
        chk("ins_valid", 64'(ins_valid_o), 64'(exp_q.size() != 0));
        if (ins_valid_o && exp_q.size() != 0) begin
          e = exp_q[0];
          chk("ins_data", 64'(ins_data_o), 64'(e.data));
          chk("ins_id", 64'(ins_id_o), 64'(e.id));
          chk("ins_slot", 64'(ins_slot_o), 64'(e.slot));
          chk("ins_last", 64'(ins_last_o), 64'(e.last));
          if (ins_ready_i) begin
            pl = e.last;
            void'(exp_q.pop_front());
          end
        end
      end
      @(posedge clk or posedge reset_n);
      if (reset_n) begin
        exp_q.delete();
        mblk = 0;
        mdrop = '0;
      end else begin
        rdy = mblk < DEPTH;
        if (flush_i) begin
          exp_q.delete();
          mblk = 0;
        end else begin
          if (pl) mblk--;
          if (blk_valid_i) begin
            if (rdy) begin
              for (int s = 0; s < IPB; s++) exp_q.push_back('{cur_w[s], blk_id_i, s, s == IPB-1});
              mblk++;
            end else if (mdrop != '1) mdrop++;
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input bit v, input logic [IDW-1:0] id);
    logic [IPB*IW-1:0] p;
    p = '0;
    for (int s = 0; s < IPB; s++) p = (p << IW) | (IPB*IW)'(cur_w[s]);
    blk_data_i = p;
    blk_id_i = id;
    blk_valid_i = v;
  endtask

  task automatic rand_words();
    for (int s = 0; s < IPB; s++) cur_w[s] = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    offer(1'b0, '0);
    flush_i = 1'b0;
    ins_ready_i = 1'b1;
    while (exp_q.size() != 0 && n < 200) begin
      cyc();
      n++;
    end
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    repeat (2) cyc();
  endtask

  initial begin
    for (int s = 0; s < IPB; s++) cur_w[s] = '0;
    repeat (2) cyc();
    reset_n = 1'b0;
    cyc();
    // Single block, always-ready consumer.
    ins_ready_i = 1'b1;
    cur_w = '{32'h00500513, 32'h00520293, 32'h00600593, 32'h00628313};
    offer(1'b1, 7'h01);
    cyc();
    offer(1'b0, '0);
    repeat (6) cyc();
    // Back-to-back blocks.
    offer(1'b1, 7'h01);
    cyc();
    cur_w = '{32'h00500513, 32'h00500513, 32'h00600593, 32'h00600593};
    offer(1'b1, 7'h02);
    cyc();
    offer(1'b0, '0);
    repeat (10) cyc();
    // Back-pressure: fill the queue, count drops, then release the consumer.
    ins_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rand_words();
      offer(1'b1, 7'(i + 3));
      cyc();
    end
    ins_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rand_words();
      offer(1'b1, 7'(i + 20));
      cyc();
    end
    drain();
    // Random offers, stalls and occasional flushes.
    for (int i = 0; i < 500; i++) begin
      ins_ready_i = $urandom_range(0, 3) != 0;
      flush_i = $urandom_range(0, 40) == 0;
      rand_words();
      offer(1'($urandom_range(0, 1)), 7'($urandom));
      cyc();
    end
    drain();
    // Flush while slot 2 of block 0x01 is presented, with a block offered the same cycle.
    cur_w = '{32'h00500513, 32'h00520293, 32'h00600593, 32'h00628313};
    offer(1'b1, 7'h01);
    cyc();
    offer(1'b0, '0);
    repeat (2) cyc();
    flush_i = 1'b1;
    rand_words();
    offer(1'b1, 7'h02);
    cyc();
    flush_i = 1'b0;
    offer(1'b0, '0);
    repeat (4) cyc();
    // Asynchronous reset pulse in the middle of issuing, then resume.
    rand_words();
    offer(1'b1, 7'h05);
    cyc();
    rand_words();
    offer(1'b1, 7'h06);
    cyc();
    offer(1'b0, '0);
    cyc();
    reset_n = 1'b1;
    #3;
    reset_n = 1'b0;
    cyc();
    rand_words();
    offer(1'b1, 7'h07);
    cyc();
    drain();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/instr_block_issue_queue.md
Name: instr_block_issue_queue

Overview:
Front-end buffer between the block source and the decode stage. Accepts whole instruction blocks (INSTR_PER_BLOCK words plus a block ID) under a valid/ready handshake. Blocks are queued in a DEPTH-entry FIFO. The queue then issues them one instruction per cycle, in program order, with ID, slot index and last-of-block tag. It generalises the fixed 4x32-bit, ID-tagged, ready-less block input to a parametrised, back-pressured, flushable interface.

Parameters:
INSTR_W, 32, width of one instruction word
INSTR_PER_BLOCK, 4, instructions per block (power of 2, >=2)
ID_W, 7, block ID width
DEPTH, 4, block FIFO entries (power of 2, >=2)
DROP_W, 16, width of the rejected-offer counter

Ports:
clk  in  1  clock
reset_n  in  1  reset, asynchronous, active-high
blk_valid_i  in  1  block offered
blk_ready_o  out  1  queue can accept a block
blk_data_i  in  INSTR_PER_BLOCK*INSTR_W  block payload, slot 0 in MSBs (program order, MSB first)
blk_id_i  in  ID_W  block ID
flush_i  in  1  synchronous discard of all queued/in-flight instructions
ins_valid_o  out  1  instruction available
ins_ready_i  in  1  consumer accepts instruction
ins_data_o  out  INSTR_W  instruction word
ins_id_o  out  ID_W  ID of owning block
ins_slot_o  out  max(1,$clog2(INSTR_PER_BLOCK))  slot index within block
ins_last_o  out  1  final slot of block
occupancy_o  out  $clog2(DEPTH+1)  blocks held, including the one being issued
drop_cnt_o  out  DROP_W  saturating count of cycles where the offer was not accepted

Behaviour:
- Reset (reset_n=1, async): FIFO empty, slot counter 0, drop counter 0. Outputs: blk_ready_o=1, ins_valid_o=0, ins_data_o/ins_id_o/ins_slot_o=0, ins_last_o=0, occupancy_o=0, drop_cnt_o=0. Reset asserted mid-operation discards everything immediately.
- blk_ready_o = !full. It is registered-state based only and never depends on ins_ready_i in the same cycle.
- Block accepted on a rising edge when blk_valid_i && blk_ready_o, and is written at the tail.
- Latency: a block accepted at edge T into an empty queue gives ins_valid_o=1, slot 0, in the cycle after T.
- ins_valid_o = !empty. Data/ID come from the head entry, word-selected by the slot counter.
- Output transfer on edge when ins_valid_o && ins_ready_i. Slot counter increments. On the last slot it wraps to 0 and the head pops in the same edge.
- Held outputs stable while ins_valid_o && !ins_ready_i.
- Push and pop on the same edge: occupancy unchanged.
- Full queue: blk_ready_o=0 even if a pop happens that edge; the block can be accepted the next cycle.
- Pointers wrap modulo DEPTH, with a separate full/empty flag (or extra pointer bit) to disambiguate.
- drop_cnt_o increments on each edge with blk_valid_i && !blk_ready_o, saturating at all-ones. Not cleared by flush.
- flush_i (edge): empties FIFO, slot counter to 0, occupancy 0.
  - A block offered in the same cycle is discarded (flush wins) and is not counted as a drop.
  - ins_valid_o=0 the next cycle.
  - A transfer in the flush cycle still counts as delivered to the consumer.
- No state machine beyond FIFO pointers plus the slot counter; the issue side is implicitly IDLE (empty) or ISSUING.

Decomposition:
- Package instr_block_pkg:
  - default INSTR_W, INSTR_PER_BLOCK, ID_W.
  - Typedef blk_entry_t {id, payload}.
  - Function slot_word(payload, slot) doing the MSB-first extraction.
  - NOP constant 32'h00000013 for benches.
- Sub-module instr_block_fifo: parametrised synchronous FIFO of blk_entry_t with full/empty/count outputs.
- Slot counter, output mux, flush and drop counter live in the top.

Test Plan:
- Reset release, then block {00500513,00520293,00600593,00628313} ID 0x01, ins_ready_i=1 -> next cycle begins 4 consecutive issues: 00500513/slot0 … 00628313/slot3 with last=1, all ID 0x01. Then ins_valid_o=0 and occupancy back to 0.
- Back-to-back blocks ID 0x01 and 0x02 (second {00500513,00500513,00600593,00600593}), consumer always ready -> 8 contiguous issues with no bubble, ID changing after the first last=1.
- ins_ready_i=0, offer 6 blocks continuously -> first 4 accepted, blk_ready_o=0 afterwards, occupancy_o=4, drop_cnt_o increments every stalled cycle. Release ready -> blk_ready_o rises the cycle after the 4th issue of the head block.
- Random ins_ready_i stalls -> ins_data_o/id/slot stable during each stall, and order is identical to the unstalled run.
- flush_i at slot 2 of block 0x01, with a block offered the same cycle -> ins_valid_o=0 next cycle, occupancy 0, offered block not issued, drop_cnt_o unchanged.
- reset_n pulsed mid-issue with DEPTH=2, INSTR_PER_BLOCK=8 configuration -> all outputs return to reset values asynchronously, and the queue resumes correctly afterwards.
